// File: rtl/register_file.sv
// rtl/register_file.sv - register file with bypassed read ports and a streaming dump port
//
// Purpose: general-purpose register file for the datapath. It has two
// combinational read ports, one clocked write port with write-to-read
// bypass, and a register 0 that always reads as zero. A dump port streams
// every register out, from index 0 to NREGS-1, over a valid/ready handshake.
//
// Ports:
//   clk          clock; all state changes on its rising edge
//   reset        asynchronous active-high reset; clears everything
//   we/waddr/wdata   write port; writes to address 0 are discarded
//   raddr1/rdata1    read port 1 (combinational, bypassed)
//   raddr2/rdata2    read port 2 (combinational, bypassed)
//   dump_start   one-cycle request to begin a dump (ignored while busy)
//   dump_busy    high while a dump is in progress
//   dump_valid   current dump beat is valid
//   dump_ready   consumer accepts the current beat
//   dump_addr    index of the current beat
//   dump_data    captured value of the current beat
module register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              dump_start,
    output logic              dump_busy,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREGS - 1);

    logic [DATA_W-1:0] regs_q [NREGS];

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] dump_addr_q, dump_addr_d;
    logic [DATA_W-1:0] dump_data_q, dump_data_d;

    logic [ADDR_W-1:0] dump_next_addr;

    // Shared read rule for both read ports and the dump capture: address 0
    // is zero, a write presented this cycle to the same address wins, and
    // otherwise the stored word is returned.
    function automatic logic [DATA_W-1:0] fwd_read(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              wr_en,
        input logic [ADDR_W-1:0] wr_addr,
        input logic [DATA_W-1:0] wr_data
    );
        if (addr == '0) begin
            return '0;
        end else if (wr_en && (wr_addr == addr)) begin
            return wr_data;
        end else begin
            return stored;
        end
    endfunction

    assign rdata1 = fwd_read(raddr1, regs_q[raddr1], we, waddr, wdata);
    assign rdata2 = fwd_read(raddr2, regs_q[raddr2], we, waddr, wdata);

    // Register array; index 0 is never written so it stays zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign dump_next_addr = dump_addr_q + ADDR_W'(1);

    // Dump sequencer. The beat is captured once when its index is reached
    // and then held, so writes during a stall do not disturb the beat on
    // the wire; later indices pick up such writes when they are captured.
    always_comb begin
        state_d     = state_q;
        dump_addr_d = dump_addr_q;
        dump_data_d = dump_data_q;
        case (state_q)
            IDLE: begin
                if (dump_start) begin
                    state_d     = SEND;
                    dump_addr_d = '0;
                    dump_data_d = '0;
                end
            end
            default: begin
                if (dump_ready) begin
                    if (dump_addr_q == LAST_ADDR) begin
                        state_d = IDLE;
                    end else begin
                        dump_addr_d = dump_next_addr;
                        dump_data_d = fwd_read(dump_next_addr, regs_q[dump_next_addr],
                                               we, waddr, wdata);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            dump_addr_q <= '0;
            dump_data_q <= '0;
        end else begin
            state_q     <= state_d;
            dump_addr_q <= dump_addr_d;
            dump_data_q <= dump_data_d;
        end
    end

    assign dump_valid = (state_q == SEND);
    assign dump_busy  = (state_q == SEND);
    assign dump_addr  = dump_addr_q;
    assign dump_data  = dump_data_q;

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - scoreboard bench for register_file
module tb_register_file;

    logic        clk;
    logic        reset;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rdata1, rdata2;
    logic        dump_start;
    logic        dump_busy;
    logic        dump_valid;
    logic        dump_ready;
    logic [4:0]  dump_addr;
    logic [31:0] dump_data;

    register_file #(.DATA_W(32), .ADDR_W(5), .NREGS(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .raddr1     (raddr1),
        .raddr2     (raddr2),
        .rdata1     (rdata1),
        .rdata2     (rdata2),
        .dump_start (dump_start),
        .dump_busy  (dump_busy),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: register contents and the beat the dump should present.
    logic [31:0] model [32];
    bit          m_active;
    int          m_idx;
    logic [36:0] exp_q [$];   // {addr, data} of each beat, in order

    function automatic logic [31:0] ref_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (we && waddr == a) return wdata;
        return model[a];
    endfunction

    // A captured beat holds the register's content as of its capture edge,
    // including a write presented at that same edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
            m_active = 0;
            m_idx = 0;
            exp_q.delete();
        end else begin
            if (we && waddr != 0) model[waddr] = wdata;
            if (!m_active) begin
                if (dump_start) begin
                    m_active = 1;
                    m_idx = 0;
                    exp_q.push_back({5'd0, 32'h0});
                end
            end else if (dump_ready) begin
                if (m_idx == 31) begin
                    m_active = 0;
                end else begin
                    m_idx++;
                    exp_q.push_back({5'(m_idx), model[m_idx]});
                end
            end
        end
    end

    // Monitor: compares the presented beat against the scoreboard front,
    // every cycle it is valid (so stalls also verify stability).
    always @(negedge clk) begin
        logic [36:0] e;
        if (reset) begin
            chk("rst_valid", {31'h0, dump_valid}, 32'h0);
            chk("rst_busy", {31'h0, dump_busy}, 32'h0);
        end else begin
            chk("mon_valid", {31'h0, dump_valid}, {31'h0, m_active});
            chk("mon_busy", {31'h0, dump_busy}, {31'h0, m_active});
            if (dump_valid) begin
                if (exp_q.size() == 0) begin
                    chk("mon_unexpected_beat", {27'h0, dump_addr}, 32'hFFFFFFFF);
                end else begin
                    e = exp_q[0];
                    chk("beat_addr", {27'h0, dump_addr}, {27'h0, e[36:32]});
                    chk("beat_data", dump_data, e[31:0]);
                    if (dump_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic rd_check(input string name, input logic [4:0] a1, input logic [4:0] a2);
        raddr1 = a1;
        raddr2 = a2;
        #1;
        chk({name, "_p1"}, rdata1, ref_read(a1));
        chk({name, "_p2"}, rdata2, ref_read(a2));
    endtask

    task automatic wait_idx(input int idx);
        int n;
        n = 0;
        while (!(m_active && m_idx == idx) && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) chk("timeout_wait_idx", 32'(n), 32'(idx));
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (m_active && n < 400) begin
            step();
            n++;
        end
        if (n >= 400) chk("timeout_wait_done", 32'(n), 32'h0);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        we = 0; waddr = 0; wdata = 0; raddr1 = 0; raddr2 = 0;
        dump_start = 0; dump_ready = 0;
        #3;
        chk("reset_dump_addr", {27'h0, dump_addr}, 32'h0);
        chk("reset_dump_data", dump_data, 32'h0);
        step(); step();
        reset = 1'b0;

        // basic read/write
        rd_check("pre_r5", 5'd5, 5'd5);
        chk("pre_r5_zero", rdata1, 32'h0);
        we = 1; waddr = 5; wdata = 32'hDEADBEEF;
        step();
        we = 0;
        rd_check("post_r5", 5'd5, 5'd5);
        chk("post_r5_val", rdata2, 32'hDEADBEEF);

        // r0 and bypass
        we = 1; waddr = 0; wdata = 32'h1234;
        rd_check("r0_wr", 5'd0, 5'd0);
        step();
        we = 0;
        rd_check("r0_after", 5'd0, 5'd0);
        chk("r0_zero", rdata1, 32'h0);
        we = 1; waddr = 7; wdata = 32'hA5A5A5A5;
        rd_check("bypass_r7", 5'd7, 5'd7);
        chk("bypass_r7_p1", rdata1, 32'hA5A5A5A5);
        chk("bypass_r7_p2", rdata2, 32'hA5A5A5A5);
        step();
        we = 0;

        // random read/write traffic
        for (int i = 0; i < 60; i++) begin
            logic [4:0] a1, a2;
            we = 1'($urandom_range(0, 1));
            waddr = 5'($urandom);
            wdata = $urandom;
            a1 = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom);
            a2 = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom);
            rd_check("rand_rd", a1, a2);
            step();
        end
        we = 0;

        // full dump with ready held high
        for (int i = 1; i < 32; i++) begin
            we = 1; waddr = 5'(i); wdata = i * 32'h0101;
            step();
        end
        we = 0;
        dump_ready = 1;
        dump_start = 1;
        step();
        dump_start = 0;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (dump_busy) n++;
            else break;
        end
        chk("full_dump_len", 32'(n), 32'd32);
        step();

        // backpressure at beat 3 with writes to r3/r4 during the stall
        dump_start = 1;
        step();
        dump_start = 0;
        wait_idx(3);
        dump_ready = 0;
        for (int k = 0; k < 5; k++) begin
            we = (k < 2);
            waddr = (k == 0) ? 5'd3 : 5'd4;
            wdata = 32'hFFFF0000;
            step();
        end
        we = 0;
        chk("stall_beat3_addr", {27'h0, dump_addr}, 32'd3);
        chk("stall_beat3_data", dump_data, 32'h00000303);
        dump_ready = 1;
        step();
        chk("beat4_data", dump_data, 32'hFFFF0000);
        wait_done();

        // random ready and random writes during a dump
        dump_start = 1;
        step();
        dump_start = 0;
        n = 0;
        while (m_active && n < 300) begin
            dump_ready = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            waddr = 5'($urandom);
            wdata = $urandom;
            step();
            n++;
        end
        if (n >= 300) chk("timeout_rand_dump", 32'(n), 32'h0);
        we = 0;
        dump_ready = 1;
        step();

        // start while busy, then reset mid-dump
        dump_start = 1;
        step();
        dump_start = 0;
        wait_idx(10);
        dump_start = 1;
        step();
        dump_start = 0;
        chk("busy_start_ignored", {27'h0, dump_addr}, 32'd11);
        wait_idx(12);
        chk("at_addr12", {27'h0, dump_addr}, 32'd12);
        reset = 1;
        #1;
        chk("async_rst_valid", {31'h0, dump_valid}, 32'h0);
        chk("async_rst_busy", {31'h0, dump_busy}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            rd_check("rst_rd", 5'($urandom), 5'($urandom));
            chk("rst_rd_zero", rdata1 | rdata2, 32'h0);
        end
        step();
        reset = 0;
        we = 1; waddr = 9; wdata = 32'h13579BDF;
        step();
        we = 0;
        rd_check("post_rst_wr", 5'd9, 5'd5);
        chk("post_rst_r9", rdata1, 32'h13579BDF);
        chk("no_resume", {31'h0, dump_valid}, 32'h0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/register_file.md
# register_file

General-purpose register file for the RISC datapath: two combinational read ports for operand fetch, one clocked write port for write-back, and a sequential dump port. The write port includes write-to-read bypass, and register 0 is hardwired to zero. The dump port streams every register out over a valid/ready handshake for debug and state inspection. It sits between decode, which drives the read addresses, and write-back, which drives the write port. It complements the single load-enabled `register` block.

## Interface
- `DATA_W`, 32, width of each register.
- `ADDR_W`, 5, register address width.
- `NREGS`, 32, number of registers (must equal 2**ADDR_W).

- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `we`  in  1  write enable.
- `waddr`  in  ADDR_W  write address.
- `wdata`  in  DATA_W  write data.
- `raddr1`, `raddr2`  in  ADDR_W  read addresses.
- `rdata1`, `rdata2`  out  DATA_W  combinational read data.
- `dump_start`  in  1  one-cycle request to begin a dump.
- `dump_busy`  out  1  high while a dump is in progress.
- `dump_valid`  out  1  the dump beat is valid.
- `dump_ready`  in  1  the consumer accepts the beat.
- `dump_addr`  out  ADDR_W  index of the current beat.
- `dump_data`  out  DATA_W  value of the current beat (registered).

## Operation
- **Reset:** all registers = 0; `dump_busy` = 0, `dump_valid` = 0, `dump_addr` = 0, `dump_data` = 0; FSM = IDLE.
- **Write:** on a rising edge with `we`=1 and `waddr`≠0, reg[`waddr`] ← `wdata`. Writes to address 0 are discarded.
- **Read:** `rdataN` = 0 if `raddrN`=0.
  - Otherwise, if `we`=1 and `waddr`=`raddrN`, `rdataN` = `wdata` (bypass).
  - Otherwise `rdataN` = reg[`raddrN`].
  - Both ports are fully independent and may use the same address.
- **Dump FSM, two states:**
  - IDLE: `dump_valid`=0, `dump_busy`=0. On `dump_start`=1 at an edge: go to SEND, set `dump_addr`←0, and capture `dump_data` ← value of reg 0, which is 0.
  - SEND: `dump_valid`=1, `dump_busy`=1.
    - On an edge with `dump_ready`=1 and `dump_addr`=NREGS-1: go to IDLE.
    - On an edge with `dump_ready`=1 and `dump_addr`<NREGS-1: `dump_addr`++ and `dump_data` ← bypassed read of the new index, using the same rule as the read ports and evaluated in that cycle.
    - With `dump_ready`=0: hold all dump outputs.
- **Stability:** `dump_addr` and `dump_data` never change while `dump_valid`=1 and `dump_ready`=0. This holds even if the register at `dump_addr` is written during the stall; the beat keeps its captured value.
- **Later indices:** writes to indices not yet dumped are reflected when those indices are captured.
- **Start while busy:** `dump_start` is ignored in SEND.
- **Index width:** `dump_addr` never wraps past NREGS-1; the dump terminates there.

## Timing
- Read ports: zero latency, purely combinational from `raddrN`, `we`, `waddr`, `wdata` and the register array.
- Write: visible in the array from the edge after it is presented; visible on the read ports in the same cycle via bypass.
- Dump:
  - With `dump_start` sampled at edge N, `dump_valid` rises after edge N.
  - With `dump_ready` held high, a full dump takes exactly NREGS consecutive beats. The last beat (addr NREGS-1) is accepted at edge N+NREGS, and `dump_valid`/`dump_busy` fall after that edge.
  - A new `dump_start` is accepted at the earliest at edge N+NREGS+1.
- Reset asserted mid-dump: `dump_valid` and `dump_busy` fall immediately (asynchronously), and all registers clear. No partial dump resumes after reset release.
- Reset release: the first write takes effect on the first rising edge with `reset`=0.

## Test plan
- **Reset and basic read/write:**
  - Stimulus: assert `reset`, release, write 32'hDEADBEEF to r5, then read r5 on both ports.
  - Required: 0 before the write; 32'hDEADBEEF after.
- **R0 and bypass:**
  - Stimulus: write 32'h1234 to r0 and read r0; then in one cycle write 32'hA5A5A5A5 to r7 with `raddr1`=7, `raddr2`=7.
  - Required: r0 reads 0; both ports show 32'hA5A5A5A5 in the same cycle.
- **Full dump:**
  - Stimulus: preload r[i]=i*16'h0101 for i=1..31, pulse `dump_start`, hold `dump_ready`=1.
  - Required: 32 beats with addr 0..31, data 0 then i*16'h0101; `dump_busy` low one cycle after beat 31.
- **Backpressure:**
  - Stimulus: during a dump, drop `dump_ready` for 5 cycles at addr 3 and write 32'hFFFF0000 to r3 and r4 during the stall.
  - Required: beat 3 holds its old value throughout the stall; beat 4 shows 32'hFFFF0000.
- **Start while busy and reset mid-dump:**
  - Stimulus: pulse `dump_start` at addr 10, then assert `reset` at addr 12.
  - Required: the extra start is ignored (addr continues 10→11→12); on reset, `dump_valid`/`dump_busy` go to 0 at once and all reads return 0.
